// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
// Width helpers, the status bundle and the parameter legality check.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // COUNT needs one extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 0) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level < depth);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one registered
// read port. A read and a write to the same slot return the old word.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the storage array has no reset; only the read register does, so the array maps onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: default assignment first so every path drives rd_data_d and no latch is inferred.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // NOTE: non-blocking assignments in clocked blocks; the old word is read before the same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered read data, occupancy-decoded
// status flags and sticky overflow/underflow reporting.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic                   WR,
    input  logic [WIDTH-1:0]       dataIn,
    input  logic                   RD,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   VALID,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   ALMOST_EMPTY,
    output logic                   ALMOST_FULL,
    output logic                   OVF,
    output logic                   UDF
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("param_sync_fifo: DEPTH must be a power of two >= 2, AF_LEVEL <= DEPTH, AE_LEVEL < DEPTH");
    end

    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d,  count_q;
    logic          valid_d,  valid_q;
    logic          ovf_d,    ovf_q;
    logic          udf_d,    udf_q;

    logic          clr;
    logic          rd_ok;
    logic          wr_ok;
    fifo_status_t  status;

    always_comb begin
        status.empty        = (count_q == '0);
        status.full         = (count_q == FULL_C);
        status.almost_empty = (count_q <= AE_C);
        status.almost_full  = (count_q >= AF_C);
    end

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign clr   = EN & CLR;
    assign rd_ok = EN & RD & ~status.empty;
    assign wr_ok = EN & WR & (~status.full | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else if (EN) begin
            valid_d = rd_ok;
            ovf_d   = ovf_q | (WR & status.full & ~rd_ok);
            udf_d   = udf_q | (RD & status.empty);
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // A flush must leave dataOut untouched, so neither memory port fires during CLR.
    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .wr_en   (wr_ok & ~clr),
        .wr_addr (wr_ptr_q),
        .wr_data (dataIn),
        .rd_en   (rd_ok & ~clr),
        .rd_addr (rd_ptr_q),
        .rd_data (dataOut)
    );

    assign VALID        = valid_q;
    assign COUNT        = count_q;
    assign EMPTY        = status.empty;
    assign FULL         = status.full;
    assign ALMOST_EMPTY = status.almost_empty;
    assign ALMOST_FULL  = status.almost_full;
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: a queue-based reference model drives
// expectations, per-instance monitors check popped words as VALID appears.
module tb_param_sync_fifo;

    logic clk;
    logic rst_n;

    // Instance 0: defaults (WIDTH=32, DEPTH=8, AF=7, AE=1)
    logic        en1, clr1, wr1, rd1;
    logic [31:0] din1, dout1;
    logic        valid1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [3:0]  count1;

    // Instance 1: WIDTH=8, DEPTH=16, AF=12, AE=3
    logic        en2, clr2, wr2, rd2;
    logic [7:0]  din2, dout2;
    logic        valid2, empty2, full2, ae2, af2, ovf2, udf2;
    logic [4:0]  count2;

    param_sync_fifo u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .EN(en1), .CLR(clr1), .WR(wr1), .dataIn(din1), .RD(rd1),
        .dataOut(dout1), .VALID(valid1), .COUNT(count1), .EMPTY(empty1), .FULL(full1),
        .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .OVF(ovf1), .UDF(udf1)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u_dut2 (
        .Clk(clk), .Rst_n(rst_n), .EN(en2), .CLR(clr2), .WR(wr2), .dataIn(din2), .RD(rd2),
        .dataOut(dout2), .VALID(valid2), .COUNT(count2), .EMPTY(empty2), .FULL(full2),
        .ALMOST_EMPTY(ae2), .ALMOST_FULL(af2), .OVF(ovf2), .UDF(udf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as plain queues, expected popped words in scoreboards.
    logic [31:0] mq1[$], mq2[$];
    logic [31:0] sb1[$], sb2[$];
    bit          m_ovf[2], m_udf[2], m_valid[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int sel);
        return (sel == 0) ? 8 : 16;
    endfunction

    task automatic model_reset();
        mq1.delete(); mq2.delete(); sb1.delete(); sb2.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 0; m_udf[i] = 0; m_valid[i] = 0;
        end
    endtask

    task automatic model_step(input int sel, input bit en, input bit clr, input bit wr,
                              input logic [31:0] din, input bit rd);
        int  sz;
        bit  rd_ok, wr_ok;
        logic [31:0] w;
        sz = (sel == 0) ? mq1.size() : mq2.size();
        if (!en) return;
        if (clr) begin
            if (sel == 0) mq1.delete(); else mq2.delete();
            m_ovf[sel] = 0; m_udf[sel] = 0; m_valid[sel] = 0;
            return;
        end
        rd_ok = rd && (sz > 0);
        wr_ok = wr && ((sz < depth_of(sel)) || rd_ok);
        if (wr && sz == depth_of(sel) && !rd_ok) m_ovf[sel] = 1;
        if (rd && sz == 0) m_udf[sel] = 1;
        m_valid[sel] = rd_ok;
        if (rd_ok) begin
            if (sel == 0) begin w = mq1.pop_front(); sb1.push_back(w); end
            else          begin w = mq2.pop_front(); sb2.push_back(w); end
        end
        if (wr_ok) begin
            if (sel == 0) mq1.push_back(din);
            else          mq2.push_back(din & 32'hFF);
        end
    endtask

    task automatic check_status(input int sel);
        int sz, af, ae;
        logic [31:0] cnt_a;
        logic [6:0]  fl_a, fl_e;
        if (sel == 0) begin
            sz = mq1.size(); af = 7; ae = 1;
            cnt_a = 32'(count1);
            fl_a  = {empty1, full1, ae1, af1, ovf1, udf1, valid1};
        end else begin
            sz = mq2.size(); af = 12; ae = 3;
            cnt_a = 32'(count2);
            fl_a  = {empty2, full2, ae2, af2, ovf2, udf2, valid2};
        end
        fl_e = {sz == 0, sz == depth_of(sel), sz <= ae, sz >= af, m_ovf[sel], m_udf[sel], m_valid[sel]};
        check($sformatf("count[%0d]", sel), cnt_a, sz);
        check($sformatf("flags[%0d] {E,F,AE,AF,OVF,UDF,VALID}", sel), 32'(fl_a), 32'(fl_e));
    endtask

    // One clock cycle on the selected instance; the other is held with EN=0.
    task automatic cycle(input int sel, input bit en, input bit clr, input bit wr,
                         input logic [31:0] din, input bit rd);
        if (sel == 0) begin
            en1 = en; clr1 = clr; wr1 = wr; din1 = din; rd1 = rd; en2 = 1'b0;
        end else begin
            en2 = en; clr2 = clr; wr2 = wr; din2 = din[7:0]; rd2 = rd; en1 = 1'b0;
        end
        model_step(sel, en, clr, wr, din, rd);
        @(posedge clk);
        @(negedge clk);
        check_status(sel);
    endtask

    // Monitors: a word is newly presented when VALID is high after an edge with EN=1.
    initial begin
        logic e, r;
        forever begin
            @(posedge clk);
            e = en1; r = rst_n;
            #1;
            if (r && e && valid1) begin
                if (sb1.size() == 0) check("spurious_valid[0]", 32'(valid1), 32'd0);
                else                 check("rdata[0]", dout1, sb1.pop_front());
            end
        end
    end

    initial begin
        logic e, r;
        forever begin
            @(posedge clk);
            e = en2; r = rst_n;
            #1;
            if (r && e && valid2) begin
                if (sb2.size() == 0) check("spurious_valid[1]", 32'(valid2), 32'd0);
                else                 check("rdata[1]", 32'(dout2), sb2.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        en1 = 0; clr1 = 0; wr1 = 0; rd1 = 0; din1 = '0;
        en2 = 0; clr2 = 0; wr2 = 0; rd2 = 0; din2 = '0;
        model_reset();

        // Asynchronous reset before any clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_status(0);
        check_status(1);
        check("reset_dout[0]", dout1, 32'd0);
        check("reset_dout[1]", 32'(dout2), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain with continuous VALID
        for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 1, i, 0);
        for (int i = 0; i < 8; i++)  cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0);

        // Wrap-around
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 32'h100 + i, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 32'h200 + i, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 1);

        // Full boundary: RD+WR, then overflow, then drain to confirm contents
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1, 32'hA + i, 0);
        cycle(0, 1, 0, 1, 32'hFF, 1);
        cycle(0, 1, 0, 1, 32'hDEAD, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0, 1);

        // Empty boundary: underflow, then RD+WR on empty, flags sticky until CLR with WR
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 1, 32'h55, 1);
        repeat (3) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 32'h77, 0);
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 1, 0, 0, 0);

        // Enable gating with a VALID pulse held across EN=0
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, $urandom, 0);
        cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            cycle(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        cycle(0, 1, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            cycle(0, $urandom_range(0, 9) != 0, $urandom_range(0, 32) == 0,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

        // Reset mid-operation with COUNT=3
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, $urandom, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_status(0);
        check("midreset_dout[0]", dout1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Second parameter set: thresholds at 12 and 3
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 1, $urandom, 0);
        cycle(1, 1, 0, 1, 32'h5A, 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 200; i++)
            cycle(1, $urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0,
                  1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));

        cycle(0, 1, 0, 0, 0, 0);
        check("sb_left[0]", sb1.size(), 0);
        check("sb_left[1]", sb2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
